// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl
// Full-search motion-estimation sequencer. For one current block it walks
// every candidate motion vector in the square window -RANGE..+RANGE (x fastest,
// then y), fires one sad_go per candidate, captures the SAD result when the
// SAD unit reports sad_done, and keeps the minimum SAD with its vector.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous reset, active low
//   start      : begin a search (only looked at while idle)
//   busy       : search in progress (ISSUE/WAIT/CMP)
//   done       : one-cycle pulse when the search has finished
//   sad_go     : one-cycle pulse starting the SAD unit for cand_mvx/cand_mvy
//   sad_done   : SAD unit result valid (only looked at while waiting)
//   sad_value  : SAD result, valid with sad_done
//   cand_mvx/y : current candidate vector, signed two's complement
//   best_sad   : smallest SAD seen in the last search
//   best_mvx/y : vector belonging to best_sad, signed two's complement

module sad_search_ctrl #(
  parameter int RANGE = 8,
  parameter int MV_W  = 5,
  parameter int SAD_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sad_go,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad_value,
  output logic [MV_W-1:0]  cand_mvx,
  output logic [MV_W-1:0]  cand_mvy,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_mvx,
  output logic [MV_W-1:0]  best_mvy
);

  localparam logic [MV_W-1:0] MvMin = MV_W'(-RANGE);
  localparam logic [MV_W-1:0] MvMax = MV_W'(RANGE);
  localparam logic [MV_W-1:0] MvOne = MV_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CMP,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [MV_W-1:0]  candX_q, candX_d;
  logic [MV_W-1:0]  candY_q, candY_d;
  logic             first_q, first_d;
  logic [SAD_W-1:0] sadCap_q, sadCap_d;
  logic [SAD_W-1:0] bestSad_q, bestSad_d;
  logic [MV_W-1:0]  bestX_q, bestX_d;
  logic [MV_W-1:0]  bestY_q, bestY_d;

  // State and datapath registers. best_sad resets to all-ones so an unused
  // result reads as "nothing found"; the first flag guarantees the first
  // candidate is recorded even if it also returns all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      candX_q   <= '0;
      candY_q   <= '0;
      first_q   <= 1'b0;
      sadCap_q  <= '0;
      bestSad_q <= '1;
      bestX_q   <= '0;
      bestY_q   <= '0;
    end else begin
      state_q   <= state_d;
      candX_q   <= candX_d;
      candY_q   <= candY_d;
      first_q   <= first_d;
      sadCap_q  <= sadCap_d;
      bestSad_q <= bestSad_d;
      bestX_q   <= bestX_d;
      bestY_q   <= bestY_d;
    end
  end

  // Next-state logic. The candidate vector only moves on the way out of CMP
  // (or when a search is launched), so the SAD unit sees a stable address
  // for the whole ISSUE..WAIT window. Strict less-than keeps the earlier
  // candidate on ties. The last candidate is left in place rather than
  // stepping past the window edge.
  always_comb begin
    state_d   = state_q;
    candX_d   = candX_q;
    candY_d   = candY_q;
    first_d   = first_q;
    sadCap_d  = sadCap_q;
    bestSad_d = bestSad_q;
    bestX_d   = bestX_q;
    bestY_d   = bestY_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          candX_d = MvMin;
          candY_d = MvMin;
          first_d = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sad_done) begin
          sadCap_d = sad_value;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (first_q || (sadCap_q < bestSad_q)) begin
          bestSad_d = sadCap_q;
          bestX_d   = candX_q;
          bestY_d   = candY_q;
        end
        first_d = 1'b0;
        if (candX_q == MvMax) begin
          if (candY_q == MvMax) begin
            state_d = FIN;
          end else begin
            candX_d = MvMin;
            candY_d = candY_q + MvOne;
            state_d = ISSUE;
          end
        end else begin
          candX_d = candX_q + MvOne;
          state_d = ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CMP);
  assign done     = (state_q == FIN);
  assign sad_go   = (state_q == ISSUE);
  assign cand_mvx = candX_q;
  assign cand_mvy = candY_q;
  assign best_sad = bestSad_q;
  assign best_mvx = bestX_q;
  assign best_mvy = bestY_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl
// Bench for sad_search_ctrl with RANGE=2 (25 candidates). A behavioural SAD
// responder answers each sad_go after a configurable latency with a value
// chosen from a per-test pattern of the candidate vector. A table of complete
// searches is run and checked, followed by hand-written reset-abort sequences.

module tb_sad_search_ctrl;

  localparam int RANGE = 2;
  localparam int MV_W  = 5;
  localparam int SAD_W = 32;
  localparam int NCAND = (2 * RANGE + 1) * (2 * RANGE + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, sadGo;
  logic             sadDone = 1'b0;
  logic [SAD_W-1:0] sadValue = '0;
  logic [MV_W-1:0]  candX, candY, bestX, bestY;
  logic [SAD_W-1:0] bestSad;

  int testCount = 0;
  int failCount = 0;

  sad_search_ctrl #(.RANGE(RANGE), .MV_W(MV_W), .SAD_W(SAD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sad_go(sadGo), .sad_done(sadDone), .sad_value(sadValue),
    .cand_mvx(candX), .cand_mvy(candY), .best_sad(bestSad),
    .best_mvx(bestX), .best_mvy(bestY)
  );

  always #5 clk = ~clk;

  int cycleNum = 0;
  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Response patterns: 0 = 1000 except 37 at (1,-1); 1 = 50 at (-1,0) and
  // (2,1), 100 elsewhere; 2 = all-ones; 3 = 100 + 7|x-1| + 3|y|.
  function automatic logic [SAD_W-1:0] sadFor(int x, int y, int mode);
    int ax, ay;
    case (mode)
      0: return (x == 1 && y == -1) ? 32'd37 : 32'd1000;
      1: return ((x == -1 && y == 0) || (x == 2 && y == 1)) ? 32'd50 : 32'd100;
      2: return 32'hFFFF_FFFF;
      default: begin
        ax = (x > 1) ? x - 1 : 1 - x;
        ay = (y < 0) ? -y : y;
        return SAD_W'(100 + 7 * ax + 3 * ay);
      end
    endcase
  endfunction

  // SAD responder: sad_done pulses L cycles after the sad_go cycle, or is held
  // high permanently in hold mode. In spurious mode it also raises sad_done
  // with value 0 during ISSUE and CMP, which the sequencer must ignore.
  int respLatency = 3;
  int respMode = 0;
  bit respHold = 1'b0;
  bit respSpurious = 1'b0;
  int respCnt = 0;
  bit prevReal = 1'b0;

  always @(negedge clk) begin
    logic             nd;
    logic [SAD_W-1:0] nv;
    bit               realNow;
    realNow = 1'b0;
    nd = respHold;
    nv = sadFor(int'($signed(candX)), int'($signed(candY)), respMode);
    if (respCnt > 0) begin
      respCnt = respCnt - 1;
      if (respCnt == 0) begin
        nd = 1'b1;
        realNow = 1'b1;
      end
    end
    if (!realNow && respSpurious && (sadGo || prevReal)) begin
      nd = 1'b1;
      nv = '0;
    end
    if (sadGo) respCnt = respLatency;
    prevReal = realNow;
    sadDone = nd;
    sadValue = nv;
  end

  // Monitor: counts done and sad_go pulses, checks sad_go spacing and that
  // candidates are visited in raster order starting from (-RANGE,-RANGE).
  int doneCount = 0;
  int goCount = 0;
  int lastGo = -1;
  int expSpacing = 5;
  int spacingErr = 0;
  int seqErr = 0;

  always @(negedge clk) begin
    if (done) doneCount = doneCount + 1;
    if (sadGo) begin
      if (lastGo >= 0 && (cycleNum - lastGo) != expSpacing) spacingErr = spacingErr + 1;
      if (int'($signed(candX)) != -RANGE + (goCount % (2 * RANGE + 1)) ||
          int'($signed(candY)) != -RANGE + (goCount / (2 * RANGE + 1)))
        seqErr = seqErr + 1;
      lastGo = cycleNum;
      goCount = goCount + 1;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testCount = testCount + 1;
    if (actual !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetMonitor(input int lat, input int mode, input bit hold, input bit spur);
    respLatency = lat;
    respMode = mode;
    respHold = hold;
    respSpurious = spur;
    expSpacing = lat + 2;
    goCount = 0;
    lastGo = -1;
    spacingErr = 0;
    seqErr = 0;
    doneCount = 0;
  endtask

  // Runs one complete search and checks launch timing, result, duration,
  // pulse counts, spacing and candidate order.
  task automatic applyStimulus(input int lat, input int mode, input bit hold, input bit spur,
                               input logic [SAD_W-1:0] expSad, input int expX, input int expY,
                               input int expCycles);
    int  tStart;
    int  tDone;
    bit  found;
    resetMonitor(lat, mode, hold, spur);
    found = 1'b0;
    tDone = 0;
    @(negedge clk);
    start = 1'b1;
    tStart = cycleNum;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after start", longint'(busy), 1);
    checkOutput("sad_go after start", longint'(sadGo), 1);
    checkOutput("first cand x", longint'($signed(candX)), -RANGE);
    checkOutput("first cand y", longint'($signed(candY)), -RANGE);
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        tDone = cycleNum;
        found = 1'b1;
        break;
      end
      start = (spur && busy && (i % 7 == 3)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("done seen within bound", longint'(found), 1);
    checkOutput("cycles start to done", longint'(tDone - tStart), longint'(expCycles));
    checkOutput("busy low with done", longint'(busy), 0);
    checkOutput("best_sad", longint'(bestSad), longint'(expSad));
    checkOutput("best_mvx", longint'($signed(bestX)), longint'(expX));
    checkOutput("best_mvy", longint'($signed(bestY)), longint'(expY));
    repeat (4) @(negedge clk);
    checkOutput("done pulse count", longint'(doneCount), 1);
    checkOutput("sad_go count", longint'(goCount), NCAND);
    checkOutput("sad_go spacing errors", longint'(spacingErr), 0);
    checkOutput("raster order errors", longint'(seqErr), 0);
    checkOutput("best_sad held after done", longint'(bestSad), longint'(expSad));
    checkOutput("best_mvx held after done", longint'($signed(bestX)), longint'(expX));
    respHold = 1'b0;
    respSpurious = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int               lat;
    int               mode;
    bit               hold;
    bit               spur;
    logic [SAD_W-1:0] expSad;
    int               expX;
    int               expY;
    int               expCycles;
  } vec_t;

  vec_t tbl[5];
  int   baseDone;
  int   baseGo;
  bit   reached;

  initial begin
    tbl[0] = '{3, 0, 1'b0, 1'b0, 32'd37,        1, -1, 126};
    tbl[1] = '{3, 1, 1'b0, 1'b0, 32'd50,       -1,  0, 126};
    tbl[2] = '{2, 2, 1'b0, 1'b0, 32'hFFFF_FFFF, -2, -2, 101};
    tbl[3] = '{3, 0, 1'b0, 1'b1, 32'd37,        1, -1, 126};
    tbl[4] = '{1, 3, 1'b1, 1'b0, 32'd100,       1,  0,  76};

    // Power-on reset values.
    #2 rst = 1'b0;
    #2;
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset sad_go", longint'(sadGo), 0);
    checkOutput("reset cand_mvx", longint'(candX), 0);
    checkOutput("reset cand_mvy", longint'(candY), 0);
    checkOutput("reset best_sad", longint'(bestSad), longint'(32'hFFFF_FFFF));
    checkOutput("reset best_mvx", longint'(bestX), 0);
    checkOutput("reset best_mvy", longint'(bestY), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      $display("[TB] vector %0d: L=%0d pattern %0d", v, tbl[v].lat, tbl[v].mode);
      applyStimulus(tbl[v].lat, tbl[v].mode, tbl[v].hold, tbl[v].spur,
                    tbl[v].expSad, tbl[v].expX, tbl[v].expY, tbl[v].expCycles);
    end

    // Reset during WAIT of the tenth candidate with L=4, then restart.
    $display("[TB] reset abort during WAIT");
    resetMonitor(4, 0, 1'b0, 1'b0);
    reached = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (goCount >= 10) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("tenth sad_go reached", longint'(reached), 1);
    baseDone = doneCount;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort busy", longint'(busy), 0);
    checkOutput("abort done", longint'(done), 0);
    checkOutput("abort sad_go", longint'(sadGo), 0);
    checkOutput("abort cand_mvx", longint'(candX), 0);
    checkOutput("abort cand_mvy", longint'(candY), 0);
    checkOutput("abort best_sad", longint'(bestSad), longint'(32'hFFFF_FFFF));
    checkOutput("abort best_mvx", longint'(bestX), 0);
    checkOutput("abort best_mvy", longint'(bestY), 0);
    @(negedge clk);
    rst = 1'b1;
    baseGo = goCount;
    repeat (8) @(negedge clk);
    checkOutput("no done after abort", longint'(doneCount), longint'(baseDone));
    checkOutput("late sad_done ignored, no sad_go", longint'(goCount), longint'(baseGo));
    checkOutput("idle after late sad_done", longint'(busy), 0);
    checkOutput("best_sad untouched by late sad_done", longint'(bestSad), longint'(32'hFFFF_FFFF));
    applyStimulus(4, 0, 1'b0, 1'b0, 32'd37, 1, -1, 151);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Full-search motion-estimation sequencer that drives the SAD datapath/controller as its initiator. For one 16x16 current block it steps through every candidate motion vector in a square search window and starts one SAD computation per candidate with a `sad_go` pulse. After each `sad_done` it captures the 32-bit SAD result and keeps the minimum together with its motion vector. It sits between the frame-level scheduler (start/done) and the SAD unit, which also uses `cand_mvx`/`cand_mvy` as the reference-block address offset.

## Interface

Parameters:
- `RANGE`, 8: search range per axis; candidates are -RANGE..+RANGE on both x and y (must be ≥1).
- `MV_W`, 5: width of signed two's-complement motion-vector fields; must hold ±RANGE.
- `SAD_W`, 32: width of SAD values.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (one clock; async assert, active-low).
- `start`  in  1  begin a search; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the search is complete.
- `sad_go`  out  1  one-cycle pulse that starts the SAD unit for the current candidate.
- `sad_done`  in  1  SAD unit result-valid; sampled only in WAIT.
- `sad_value`  in  SAD_W  SAD result; valid in the cycle `sad_done`=1.
- `cand_mvx`, `cand_mvy`  out  MV_W  current candidate vector (signed); stable from `sad_go` until CMP.
- `best_sad`  out  SAD_W  minimum SAD found.
- `best_mvx`, `best_mvy`  out  MV_W  vector of `best_sad` (signed).

## Operation

- States: IDLE, ISSUE, WAIT, CMP, FIN.
- IDLE:
  - `start`=1 → ISSUE.
  - Load `cand_mvx`=`cand_mvy`=-RANGE and set the internal `first` flag.
- ISSUE:
  - Assert `sad_go` for exactly this cycle.
  - → WAIT.
- WAIT:
  - Hold until `sad_done`=1.
  - On that edge, register `sad_value` into `sad_cap` → CMP.
- CMP:
  - If `first`=1 or `sad_cap` < `best_sad` (unsigned, strict), load `best_sad`=`sad_cap` and `best_mv`=`cand_mv`; then clear `first`.
  - Ties keep the earlier candidate in raster order.
  - Advance in raster order: x increments first; when x=+RANGE it wraps to -RANGE and y increments.
  - If the vector just compared was (+RANGE,+RANGE) → FIN; otherwise → ISSUE.
- FIN:
  - `done`=1 for this cycle, `busy` deasserts.
  - → IDLE.
- Best-result registers hold their values after FIN until the next accepted `start`.
- They are reloaded by the first candidate's compare, not at `start`.
- Candidate count: (2·RANGE+1)²; 289 for RANGE=8.
- `start` while `busy` is ignored.
- `sad_done` outside WAIT is ignored.
- An all-ones `sad_value` on the first candidate is still recorded, via the `first` flag.

## Timing

- Reset (asynchronous, `rst`=0):
  - State goes to IDLE.
  - `busy`=`done`=`sad_go`=0.
  - `cand_mvx`=`cand_mvy`=0, `best_mvx`=`best_mvy`=0, `best_sad`=all-ones, `first`=0.
- Reset mid-search aborts immediately.
  - No `done` is produced.
  - Any `sad_done` that arrives later is ignored while IDLE.
- `start` sampled high in cycle T:
  - `busy`=1 and `sad_go`=1 in T+1, with `cand` = (-RANGE,-RANGE).
- Per candidate, with SAD unit latency L (cycles from `sad_go` to `sad_done`, L≥1):
  - ISSUE takes 1 cycle, WAIT takes L cycles, CMP takes 1 cycle.
  - The next `sad_go` comes L+2 cycles after the previous one.
- If `sad_done` is already high in the first WAIT cycle it is accepted (L=1).
- `done` comes one cycle after the final CMP.
- Total from `start` to `done` is (2·RANGE+1)²·(L+2)+1 cycles after T.
- `best_*` are final and stable in the `done` cycle.
- `cand_mv*` change only at the exit of CMP (and in IDLE on `start`).

## Test plan

Benches use RANGE=2 (25 candidates) with a behavioural SAD responder of fixed latency L.

- Reset during WAIT of candidate 10 (L=4):
  - Outputs go to reset values asynchronously, with no `done`.
  - A following `start` restarts at (-2,-2).
- Responder returns 1000 everywhere except 37 at (1,-1), with L=3:
  - One `done`, 126 cycles after `start`, with `best_sad`=37 and `best_mv`=(1,-1).
  - Exactly 25 `sad_go` pulses, `sad_go` spacing 5 cycles.
- Ties: value 50 at both (-1,0) and (2,1), 100 elsewhere:
  - `best_mv`=(-1,0), the earlier candidate in raster order.
- All responses all-ones (0xFFFFFFFF):
  - `best_sad`=0xFFFFFFFF and `best_mv`=(-2,-2).
- `start` pulsed repeatedly during a search, plus spurious `sad_done` pulses during ISSUE/CMP:
  - No restart, candidate sequence unchanged, result identical to a clean run.
- L=1, and `sad_done` held high continuously:
  - Each candidate takes 3 cycles, `cand_mv` walks (-2,-2),(-1,-2)…(2,2) in raster order, and `done` occurs 76 cycles after `start`.
